// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the IF-stage fetch buffer.
// Holds the default NOP encoding and the per-slot record layout.
package fetch_buffer_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] instr;
    logic        filled;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_slot_queue.sv
// In-order fetch slot ring: allocate on grant, fill on response, pop to decode.
// Pointers carry a wrap bit so full and empty are distinguishable.
module fetch_slot_queue
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc,
  input  logic [31:0]            alloc_pc,
  input  logic [31:0]            alloc_pcplus4,
  input  logic                   fill,
  input  logic [31:0]            fill_instr,
  input  logic                   pop,
  input  logic                   clear,
  output fetch_slot_t            head,
  output logic [$clog2(DEPTH):0] in_flight,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  fetch_slot_t   slots [DEPTH];
  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] read_ptr;
  logic [PW-1:0] occupancy;
  logic [AW-1:0] alloc_idx;
  logic [AW-1:0] fill_idx;
  logic [AW-1:0] read_idx;

  assign alloc_idx = alloc_ptr[AW-1:0];
  assign fill_idx  = fill_ptr[AW-1:0];
  assign read_idx  = read_ptr[AW-1:0];

  assign occupancy = alloc_ptr - read_ptr;
  assign in_flight = alloc_ptr - fill_ptr;
  assign full      = (occupancy == PW'(DEPTH));
  assign head      = slots[read_idx];

  // Alloc, fill and pop always target distinct slots: alloc needs a free slot,
  // fill targets an unfilled allocated slot, pop targets a filled one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      read_ptr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else if (clear) begin
      fill_ptr <= alloc_ptr;
      read_ptr <= alloc_ptr;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i].filled <= 1'b0;
      end
    end else begin
      if (alloc) begin
        slots[alloc_idx] <= '{pc: alloc_pc, pcplus4: alloc_pcplus4,
                               instr: '0, filled: 1'b0};
        alloc_ptr <= alloc_ptr + PW'(1);
      end
      if (fill) begin
        slots[fill_idx].instr  <= fill_instr;
        slots[fill_idx].filled <= 1'b1;
        fill_ptr <= fill_ptr + PW'(1);
      end
      if (pop) begin
        slots[read_idx].filled <= 1'b0;
        read_ptr <= read_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// IF-stage fetch controller and IF/ID pipeline register.
// Define FETCH_BUFFER_PERF_EN to add the o_perf_fetched / o_perf_bubbles counters.
module fetch_buffer #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = fetch_buffer_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        i_rst_IF,
  input  logic [31:0] i_pc_IF,
  input  logic [31:0] i_pcplus4_IF,
  input  logic        i_flush_IF,
  input  logic        i_stall_ID,
  output logic        o_en_IF,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid_ID,
  output logic [31:0] o_instr_ID,
  output logic [31:0] o_pc_ID,
  output logic [31:0] o_pcplus4_ID
`ifdef FETCH_BUFFER_PERF_EN
  ,
  output logic [31:0] o_perf_fetched,
  output logic [31:0] o_perf_bubbles
`endif
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int DW = 16;

  fetch_buffer_pkg::fetch_slot_t head;
  logic [PW-1:0] in_flight;
  logic          full;
  logic          grant;
  logic          fill;
  logic          drop;
  logic          pop;
  logic [DW-1:0] discard;
  logic [DW-1:0] discard_next;
  logic [DW-1:0] owed;

  // Memory handshake: a request is accepted in any cycle where o_imem_req and
  // i_imem_gnt are both high (o_imem_addr is taken that cycle); responses have
  // no backpressure and return in request order on i_imem_rvalid.
  assign o_imem_req  = !i_flush_IF && !full;
  assign o_imem_addr = i_pc_IF;
  assign grant       = o_imem_req && i_imem_gnt;
  assign o_en_IF     = grant || i_flush_IF;

  assign drop = i_imem_rvalid && !i_flush_IF && (discard != '0);
  assign fill = i_imem_rvalid && !i_flush_IF && (discard == '0) && (in_flight != '0);
  assign pop  = !i_flush_IF && !i_stall_ID && head.filled;

  // On redirect every in-flight request becomes owed as a discard; a response
  // arriving in the same cycle settles one of those debts immediately.
  always_comb begin
    owed         = discard + DW'(in_flight);
    discard_next = discard;
    if (i_flush_IF) begin
      discard_next = (i_imem_rvalid && (owed != '0)) ? owed - DW'(1) : owed;
    end else if (drop) begin
      discard_next = discard - DW'(1);
    end
  end

  always_ff @(posedge clk or posedge i_rst_IF) begin
    if (i_rst_IF) begin
      discard <= '0;
    end else begin
      discard <= discard_next;
    end
  end

  fetch_slot_queue #(
    .DEPTH(DEPTH)
  ) u_slots (
    .clk          (clk),
    .rst          (i_rst_IF),
    .alloc        (grant),
    .alloc_pc     (i_pc_IF),
    .alloc_pcplus4(i_pcplus4_IF),
    .fill         (fill),
    .fill_instr   (i_imem_rdata),
    .pop          (pop),
    .clear        (i_flush_IF),
    .head         (head),
    .in_flight    (in_flight),
    .full         (full)
  );

  // The head's filled bit is registered, so a response lands in ID one cycle later.
  always_ff @(posedge clk or posedge i_rst_IF) begin
    if (i_rst_IF) begin
      o_valid_ID   <= 1'b0;
      o_instr_ID   <= NOP_INSTR;
      o_pc_ID      <= '0;
      o_pcplus4_ID <= '0;
    end else if (i_flush_IF) begin
      o_valid_ID <= 1'b0;
      o_instr_ID <= NOP_INSTR;
    end else if (!i_stall_ID) begin
      if (head.filled) begin
        o_valid_ID   <= 1'b1;
        o_instr_ID   <= head.instr;
        o_pc_ID      <= head.pc;
        o_pcplus4_ID <= head.pcplus4;
      end else begin
        o_valid_ID <= 1'b0;
        o_instr_ID <= NOP_INSTR;
      end
    end
  end

`ifdef FETCH_BUFFER_PERF_EN
  always_ff @(posedge clk or posedge i_rst_IF) begin
    if (i_rst_IF) begin
      o_perf_fetched <= '0;
      o_perf_bubbles <= '0;
    end else begin
      if (pop) begin
        o_perf_fetched <= o_perf_fetched + 32'd1;
      end
      if (!i_flush_IF && !i_stall_ID && !head.filled) begin
        o_perf_bubbles <= o_perf_bubbles + 32'd1;
      end
    end
  end
`else
  // Performance counters are compiled out in this build.
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus randomized traffic
// against a queue-based behavioural model of the fetch path.
module tb_fetch_buffer;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        flush;
  logic        stall;
  logic        gnt;
  logic        rvalid;
  logic [31:0] pc;
  logic [31:0] pcp4;
  logic [31:0] rdata;
  logic        en;
  logic        req;
  logic [31:0] addr;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] id_pc;
  logic [31:0] id_pcp4;
`ifdef FETCH_BUFFER_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  fetch_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .i_rst_IF     (rst),
    .i_pc_IF      (pc),
    .i_pcplus4_IF (pcp4),
    .i_flush_IF   (flush),
    .i_stall_ID   (stall),
    .o_en_IF      (en),
    .o_imem_req   (req),
    .o_imem_addr  (addr),
    .i_imem_gnt   (gnt),
    .i_imem_rvalid(rvalid),
    .i_imem_rdata (rdata),
    .o_valid_ID   (valid),
    .o_instr_ID   (instr),
    .o_pc_ID      (id_pc),
    .o_pcplus4_ID (id_pcp4)
`ifdef FETCH_BUFFER_PERF_EN
    ,
    .o_perf_fetched(perf_fetched),
    .o_perf_bubbles(perf_bubbles)
`endif
  );

  // Behavioural model state
  typedef struct {
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [31:0] instr;
    bit          filled;
  } ent_t;
  typedef struct {
    logic [31:0] data;
    int          ready;
  } rsp_t;

  ent_t        fq[$];
  rsp_t        mem_q[$];
  logic [31:0] exp_q[$];
  int          disc;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic [31:0] m_pcp4;
  logic [31:0] m_fetched;
  logic [31:0] m_bubbles;
  logic [31:0] pc_gen;

  // Stimulus knobs
  int          gnt_pct;
  int          rv_pct;
  int          stall_pct;
  int          flush_pct;
  int          lat_max;
  bit          force_stall;
  bit          force_flush;
  logic [31:0] target;
  logic [31:0] salt;

  // Per-step samples of combinational DUT outputs
  logic        s_req;
  logic        s_en;
  logic [31:0] s_addr;

  int cyc;
  int checks;
  int errors;
  int grant_cnt;
  bit found;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic knobs(input int g, input int r, input int s, input int f, input int l);
    gnt_pct   = g;
    rv_pct    = r;
    stall_pct = s;
    flush_pct = f;
    lat_max   = l;
  endtask

  // Starts at a negedge, asserts reset asynchronously mid-phase, ends at a negedge.
  task automatic apply_reset(input logic [31:0] start_pc);
    #2;
    rst    = 1'b1;
    gnt    = 1'b0;
    rvalid = 1'b0;
    flush  = 1'b0;
    stall  = 1'b0;
    #1;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_pcp4", id_pcp4, 32'd0);
`ifdef FETCH_BUFFER_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'd0);
    chk("rst_perf_bubbles", perf_bubbles, 32'd0);
`endif
    fq.delete();
    mem_q.delete();
    disc      = 0;
    m_valid   = 1'b0;
    m_instr   = NOP;
    m_pc      = '0;
    m_pcp4    = '0;
    m_fetched = '0;
    m_bubbles = '0;
    pc_gen    = start_pc;
    pc        = start_pc;
    pcp4      = start_pc + 32'd4;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check comb outputs, advance model at posedge, check ID.
  task automatic step();
    bit   m_req;
    bit   m_en;
    bit   grant;
    bit   head_filled;
    bit   load;
    int   inflight;
    int   idx;
    rsp_t r;

    stall  = force_stall || ($urandom_range(99) < stall_pct);
    flush  = force_flush || ($urandom_range(99) < flush_pct);
    gnt    = ($urandom_range(99) < gnt_pct);
    rvalid = 1'b0;
    rdata  = $urandom();
    if (mem_q.size() > 0 && mem_q[0].ready <= cyc && $urandom_range(99) < rv_pct) begin
      r      = mem_q.pop_front();
      rvalid = 1'b1;
      rdata  = r.data;
    end
    pc   = pc_gen;
    pcp4 = pc_gen + 32'd4;

    m_req = !flush && (fq.size() < DEPTH);
    grant = m_req && gnt;
    m_en  = grant || flush;
    #1;
    s_req  = req;
    s_en   = en;
    s_addr = addr;
    chk("imem_req", {31'd0, req}, {31'd0, m_req});
    chk("en_if", {31'd0, en}, {31'd0, m_en});
    chk("imem_addr", addr, pc);

    @(posedge clk);
    #1;
    head_filled = (fq.size() > 0) && fq[0].filled;
    if (flush) begin
      inflight = 0;
      foreach (fq[i]) if (!fq[i].filled) inflight++;
      disc = disc + inflight;
      if (rvalid && disc > 0) disc--;
      fq.delete();
      m_valid = 1'b0;
      m_instr = NOP;
    end else begin
      load = !stall && head_filled;
      if (!stall) begin
        if (head_filled) begin
          m_valid   = 1'b1;
          m_instr   = fq[0].instr;
          m_pc      = fq[0].pc;
          m_pcp4    = fq[0].pcp4;
          m_fetched = m_fetched + 32'd1;
        end else begin
          m_valid   = 1'b0;
          m_instr   = NOP;
          m_bubbles = m_bubbles + 32'd1;
        end
      end
      if (rvalid) begin
        if (disc > 0) begin
          disc--;
        end else begin
          idx = -1;
          foreach (fq[i]) if (!fq[i].filled && idx < 0) idx = i;
          if (idx >= 0) begin
            fq[idx].instr  = rdata;
            fq[idx].filled = 1'b1;
          end
        end
      end
      if (load) begin
        void'(fq.pop_front());
      end
      if (grant) begin
        fq.push_back('{pc, pcp4, 32'd0, 1'b0});
      end
    end
    if (grant) begin
      r.data  = pc ^ salt;
      r.ready = cyc + 1 + int'($urandom_range(lat_max));
      mem_q.push_back(r);
    end
    if (flush) pc_gen = target;
    else if (grant) pc_gen = pc_gen + 32'd4;
    cyc++;

    chk("valid_id", {31'd0, valid}, {31'd0, m_valid});
    chk("instr_id", instr, m_instr);
    chk("pc_id", id_pc, m_pc);
    chk("pcp4_id", id_pcp4, m_pcp4);
`ifdef FETCH_BUFFER_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_bubbles", perf_bubbles, m_bubbles);
`endif
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; gnt = 1'b0; rvalid = 1'b0;
    pc = '0; pcp4 = 32'd4; rdata = '0;
    checks = 0; errors = 0; cyc = 0;
    force_stall = 1'b0; force_flush = 1'b0; target = '0;
    salt = 32'h1234_0000;
    knobs(100, 100, 0, 0, 0);
    @(negedge clk);

    // Streaming: first valid ID three cycles after release, in-order PCs
    apply_reset(32'h0);
    step(); chk("t1_valid_c1", {31'd0, valid}, 32'd0);
    step(); chk("t1_valid_c2", {31'd0, valid}, 32'd0);
    step(); chk("t1_valid_c3", {31'd0, valid}, 32'd1);
    chk("t1_pc_c3", id_pc, 32'h0);
    chk("t1_instr_c3", instr, 32'h1234_0000);
    step(); chk("t1_pc_c4", id_pc, 32'h4);
    chk("t1_instr_c4", instr, 32'h1234_0004);
    chk("t1_pcp4_c4", id_pcp4, 32'h8);
    step(); chk("t1_pc_c5", id_pc, 32'h8);

    // Stall fills the buffer: exactly DEPTH grants, then the PC holds
    apply_reset(32'h0);
    force_stall = 1'b1;
    grant_cnt   = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_req && gnt) grant_cnt++;
      chk("t2_held_valid", {31'd0, valid}, 32'd0);
    end
    chk("t2_grants", grant_cnt, DEPTH);
    #1;
    chk("t2_req_full", {31'd0, req}, 32'd0);
    chk("t2_en_full", {31'd0, en}, 32'd0);
    @(negedge clk);
    force_stall = 1'b0;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 12; i++) begin
      step();
      if (valid && exp_q.size() > 0) chk("t2_drain_pc", id_pc, exp_q.pop_front());
    end
    chk("t2_drain_done", exp_q.size(), 32'd0);

    // Flush with two requests in flight: both responses discarded
    apply_reset(32'h8);
    knobs(100, 0, 0, 0, 0);
    step(); step();
    force_flush = 1'b1;
    target      = 32'h100;
    step();
    chk("t3_en_flush", {31'd0, s_en}, 32'd1);
    chk("t3_valid_flush", {31'd0, valid}, 32'd0);
    force_flush = 1'b0;
    rv_pct      = 100;
    found       = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (valid && !found) begin
        found = 1'b1;
        chk("t3_first_pc", id_pc, 32'h100);
        chk("t3_first_instr", instr, 32'h100 ^ salt);
      end
    end
    chk("t3_found", {31'd0, found}, 32'd1);

    // Flush beats stall and a same-cycle response
    apply_reset(32'h0);
    knobs(100, 100, 0, 0, 0);
    repeat (5) step();
    rv_pct = 0;
    step();
    force_flush = 1'b1;
    force_stall = 1'b1;
    rv_pct      = 100;
    target      = 32'h200;
    step();
    chk("t4_valid", {31'd0, valid}, 32'd0);
    chk("t4_instr", instr, NOP);
    force_flush = 1'b0;
    force_stall = 1'b0;
    found       = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (valid && !found) begin
        found = 1'b1;
        chk("t4_first_pc", id_pc, 32'h200);
        chk("t4_first_instr", instr, 32'h200 ^ salt);
      end
    end
    chk("t4_found", {31'd0, found}, 32'd1);

    // Grant held low: PC holds, bubbles every cycle
    apply_reset(32'h40);
    knobs(0, 100, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_en", {31'd0, s_en}, 32'd0);
      chk("t5_addr", s_addr, 32'h40);
      chk("t5_valid", {31'd0, valid}, 32'd0);
    end
`ifdef FETCH_BUFFER_PERF_EN
    chk("t5_bubbles", perf_bubbles, 32'd5);
`endif

    // Asynchronous reset with three occupied slots, then a clean restart
    apply_reset(32'h0);
    knobs(100, 100, 0, 0, 0);
    repeat (4) step();
    force_stall = 1'b1;
    rv_pct      = 0;
    step();
    force_stall = 1'b0;
    apply_reset(32'h0);
    knobs(100, 100, 0, 0, 0);
    step(); step();
    chk("t6_valid_c2", {31'd0, valid}, 32'd0);
    step();
    chk("t6_pc_c3", id_pc, 32'h0);
    chk("t6_instr_c3", instr, 32'h1234_0000);

    // Randomized traffic
    salt = $urandom();
    for (int blk = 0; blk < 15; blk++) begin
      knobs($urandom_range(30, 100), $urandom_range(20, 100), $urandom_range(0, 50),
            $urandom_range(0, 8), $urandom_range(0, 3));
      if (blk % 5 == 4) apply_reset($urandom() & 32'hFFFF_FFFC);
      for (int i = 0; i < 200; i++) begin
        target = $urandom() & 32'hFFFF_FFFC;
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
